// File: rtl/conv_tile_controller.sv
// rtl/conv_tile_controller.sv - job sequencer and operand store for a 3x3 systolic conv engine
// Define CONV_TILE_CTRL_JOBCNT_EN to add the job_count output.
module conv_tile_controller #(
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned COMPUTE_CYCLES = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [7:0]   wr_data,
  output logic         wr_err,
  input  logic         start,
  output logic         busy,
  output logic         eng_rst,
  output logic [127:0] eng_input,
  output logic [71:0]  eng_filter,
  input  logic [31:0]  eng_result,
  output logic         res_valid,
  input  logic         res_ack,
`ifdef CONV_TILE_CTRL_JOBCNT_EN
  output logic [31:0]  result,
  output logic [15:0]  job_count
`else
  output logic [31:0]  result
`endif
);

  localparam int unsigned NUM_BYTES = 25;
  localparam logic [7:0]  RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [7:0]  RUN_LAST  = 8'(COMPUTE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [8*NUM_BYTES-1:0] opnd_q, opnd_d;
  logic                   res_valid_q, res_valid_d;
  logic [31:0]            result_q, result_d;
  logic                   wr_err_q, wr_err_d;
  logic                   ack_done;
  logic                   wr_ok;
`ifdef CONV_TILE_CTRL_JOBCNT_EN
  logic [15:0]            job_cnt_q, job_cnt_d;
`endif

  // The acknowledging cycle of DONE already counts as idle for host writes.
  assign ack_done = (state_q == S_DONE) && res_ack;
  assign wr_ok    = wr_en && (wr_addr < 5'd25) && ((state_q == S_IDLE) || ack_done);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opnd_d      = opnd_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    wr_err_d    = wr_en && !wr_ok;
`ifdef CONV_TILE_CTRL_JOBCNT_EN
    job_cnt_d   = job_cnt_q;
`endif

    if (wr_ok) begin
      opnd_d[{wr_addr, 3'b000} +: 8] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST;
          cnt_d   = '0;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          res_valid_d = 1'b1;
          result_d    = eng_result;
`ifdef CONV_TILE_CTRL_JOBCNT_EN
          job_cnt_d   = job_cnt_q + 16'd1;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = start ? S_RST : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      wr_err_q    <= 1'b0;
`ifdef CONV_TILE_CTRL_JOBCNT_EN
      job_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opnd_q      <= opnd_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      wr_err_q    <= wr_err_d;
`ifdef CONV_TILE_CTRL_JOBCNT_EN
      job_cnt_q   <= job_cnt_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign eng_rst    = (state_q != S_RUN);
  assign eng_input  = opnd_q[127:0];
  assign eng_filter = opnd_q[199:128];
  assign res_valid  = res_valid_q;
  assign result     = result_q;
  assign wr_err     = wr_err_q;
`ifdef CONV_TILE_CTRL_JOBCNT_EN
  assign job_count  = job_cnt_q;
`endif

endmodule

// File: tb/tb_conv_tile_controller.sv
// tb/tb_conv_tile_controller.sv - randomized self-checking bench for conv_tile_controller
// Engine is modelled as a 2x2 valid convolution that is only correct on the last compute cycle.
module tb_conv_tile_controller;

  localparam int RSTC = 2;
  localparam int CMPC = 12;
  localparam int LAT  = RSTC + CMPC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         start = 1'b0;
  logic         res_ack = 1'b0;
  logic         wr_err, busy, eng_rst, res_valid;
  logic [127:0] eng_input;
  logic [71:0]  eng_filter;
  logic [31:0]  eng_result, result;
`ifdef CONV_TILE_CTRL_JOBCNT_EN
  logic [15:0]  job_count;
`endif

  int          total = 0;
  int          bad = 0;
  logic [7:0]  mdl [25];
  int          eng_cnt = 0;

  always #5 clk = ~clk;

  conv_tile_controller #(.RST_CYCLES(RSTC), .COMPUTE_CYCLES(CMPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .start      (start),
    .busy       (busy),
    .eng_rst    (eng_rst),
    .eng_input  (eng_input),
    .eng_filter (eng_filter),
    .eng_result (eng_result),
    .res_valid  (res_valid),
    .res_ack    (res_ack),
    .result     (result)
`ifdef CONV_TILE_CTRL_JOBCNT_EN
    , .job_count(job_count)
`endif
  );

  function automatic logic [31:0] conv_vec(input logic [127:0] iv, input logic [71:0] fv);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int fr = 0; fr < 3; fr++)
          for (int fc = 0; fc < 3; fc++)
            s += int'(iv[((i + fr) * 4 + j + fc) * 8 +: 8]) * int'(fv[(fr * 3 + fc) * 8 +: 8]);
        r[(i * 2 + j) * 8 +: 8] = s[7:0];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mdl_in();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[k*8 +: 8] = mdl[k];
    return v;
  endfunction

  function automatic logic [71:0] mdl_flt();
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = mdl[16 + k];
    return v;
  endfunction

  always @(posedge clk) eng_cnt <= eng_rst ? 0 : eng_cnt + 1;
  assign eng_result = (!eng_rst && eng_cnt == CMPC - 1) ? conv_vec(eng_input, eng_filter) : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mdl();
    for (int k = 0; k < 25; k++) mdl[k] = 8'h00;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d, output logic err);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    err = wr_err;
    wr_en = 1'b0;
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int low);
    lat = lat0; low = 0;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
      if (!eng_rst) low++;
    end
  endtask

  task automatic load_random();
    logic e;
    for (int k = 0; k < 25; k++) begin
      mdl[k] = 8'($urandom);
      host_write(5'(k), mdl[k], e);
    end
  endtask

  task automatic test_reset();
    clear_mdl();
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (eng_rst !== 1'b1) begin bad++; $display("FAIL reset_eng_rst got=%b want=1", eng_rst); end
    total++; if (res_valid !== 1'b0 || wr_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", res_valid, wr_err); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (eng_input !== '0 || eng_filter !== '0) begin bad++; $display("FAIL reset_operands got=%h/%h want=0", eng_input, eng_filter); end
    @(negedge clk) rst = 1'b0;
    repeat (4) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_autostart got=%b want=0", busy); end
  endtask

  task automatic test_directed_conv();
    logic [7:0] tv [25];
    logic e, errs;
    int lat, low;
    tv = '{8'd10, 8'd5, 8'd1, 8'd4, 8'd6, 8'd0, 8'd12, 8'd15, 8'd3, 8'd8, 8'd0, 8'd9,
           8'd11, 8'd16, 8'd25, 8'd7, 8'd1, 8'd5, 8'd3, 8'd4, 8'd0, 8'd10, 8'd0, 8'd7, 8'd15};
    errs = 1'b0;
    for (int k = 0; k < 25; k++) begin
      host_write(5'(k), tv[k], e);
      mdl[k] = tv[k];
      errs |= e;
    end
    total++; if (errs !== 1'b0) begin bad++; $display("FAIL conv_load_err got=%b want=0", errs); end
    total++; if (eng_input !== mdl_in() || eng_filter !== mdl_flt()) begin bad++; $display("FAIL conv_operands got=%h/%h want=%h/%h", eng_input, eng_filter, mdl_in(), mdl_flt()); end
    start_job();
    wait_done(0, lat, low);
    total++; if (lat != LAT) begin bad++; $display("FAIL conv_latency got=%0d want=%0d", lat, LAT); end
    total++; if (low != CMPC) begin bad++; $display("FAIL conv_eng_rst_low got=%0d want=%0d", low, CMPC); end
    total++; if (result[7:0] !== 8'd238) begin bad++; $display("FAIL conv_r11 got=%0d want=238", result[7:0]); end
    total++; if (result !== conv_vec(mdl_in(), mdl_flt())) begin bad++; $display("FAIL conv_result got=%h want=%h", result, conv_vec(mdl_in(), mdl_flt())); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0 || result !== conv_vec(mdl_in(), mdl_flt())) begin
      bad++; $display("FAIL conv_ack got=busy%b valid%b res%h want=busy0 valid0 held", busy, res_valid, result);
    end
  endtask

  task automatic test_write_reject();
    logic e;
    int lat, low;
    start_job();
    repeat (4) tick();
    host_write(5'd5, ~mdl[5], e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL rej_busy_err got=%b want=1", e); end
    tick();
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL rej_pulse_width got=%b want=0", wr_err); end
    total++; if (eng_input[47:40] !== mdl[5]) begin bad++; $display("FAIL rej_byte5 got=%h want=%h", eng_input[47:40], mdl[5]); end
    wait_done(6, lat, low);
    total++; if (lat != LAT) begin bad++; $display("FAIL rej_latency got=%0d want=%0d", lat, LAT); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    host_write(5'd27, 8'h5A, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL rej_addr_err got=%b want=1", e); end
    total++; if (eng_input !== mdl_in() || eng_filter !== mdl_flt()) begin bad++; $display("FAIL rej_addr_operands got=%h/%h want=%h/%h", eng_input, eng_filter, mdl_in(), mdl_flt()); end
    tick();
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL rej_addr_pulse got=%b want=0", wr_err); end
  endtask

  task automatic test_done_hold();
    int lat, low;
    logic [31:0] saved;
    load_random();
    start_job();
    wait_done(0, lat, low);
    saved = conv_vec(mdl_in(), mdl_flt());
    total++; if (lat != LAT || result !== saved) begin bad++; $display("FAIL hold_first got=lat%0d res%h want=lat%0d res%h", lat, result, LAT, saved); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (res_valid !== 1'b1 || result !== saved || busy !== 1'b1) begin
        bad++; $display("FAIL hold_stable cyc=%0d got=valid%b res%h want=valid1 res%h", i, res_valid, result, saved);
      end
    end
    res_ack = 1'b1; start = 1'b1;
    tick();
    res_ack = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b1 || res_valid !== 1'b0 || eng_rst !== 1'b1) begin
      bad++; $display("FAIL b2b_enter got=busy%b valid%b eng_rst%b want=busy1 valid0 eng_rst1", busy, res_valid, eng_rst);
    end
    wait_done(0, lat, low);
    total++; if (lat != LAT || low != CMPC) begin bad++; $display("FAIL b2b_latency got=%0d/%0d want=%0d/%0d", lat, low, LAT, CMPC); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
  endtask

  task automatic test_mid_run_reset();
    int lat, low;
    load_random();
    start_job();
    repeat (RSTC + 6) tick();
    total++; if (eng_rst !== 1'b0) begin bad++; $display("FAIL mrst_in_run got=%b want=0", eng_rst); end
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || eng_rst !== 1'b1 || res_valid !== 1'b0 || result !== 32'h0) begin
      bad++; $display("FAIL mrst_state got=busy%b eng_rst%b valid%b res%h want=0 1 0 0", busy, eng_rst, res_valid, result);
    end
    total++; if (eng_input !== '0 || eng_filter !== '0) begin bad++; $display("FAIL mrst_operands got=%h/%h want=0", eng_input, eng_filter); end
    clear_mdl();
    @(negedge clk) rst = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_idle got=%b want=0", busy); end
    load_random();
    start_job();
    wait_done(0, lat, low);
    total++; if (lat != LAT || result !== conv_vec(mdl_in(), mdl_flt())) begin
      bad++; $display("FAIL mrst_rerun got=lat%0d res%h want=lat%0d res%h", lat, result, LAT, conv_vec(mdl_in(), mdl_flt()));
    end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
  endtask

  task automatic test_random();
    bit b2b;
    logic e, exp_e, w;
    logic [4:0] a;
    logic [7:0] d;
    int lat, low, n, ch;
    b2b = 1'b0;
    for (int j = 0; j < 25; j++) begin
      if (!b2b) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
          a = 5'($urandom_range(0, 31));
          d = 8'($urandom);
          res_ack = 1'($urandom_range(0, 1));
          host_write(a, d, e);
          res_ack = 1'b0;
          exp_e = (a >= 5'd25);
          if (!exp_e) mdl[a] = d;
          total++; if (e !== exp_e || busy !== 1'b0) begin bad++; $display("FAIL rnd_idle_wr addr=%0d got=err%b busy%b want=err%b busy0", a, e, busy, exp_e); end
        end
        w = 1'($urandom_range(0, 1));
        if (w) begin
          a = 5'($urandom_range(0, 24)); d = 8'($urandom);
          wr_en = 1'b1; wr_addr = a; wr_data = d;
          mdl[a] = d;
        end
        start_job();
        wr_en = 1'b0;
        total++; if (wr_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rnd_start got=err%b busy%b want=err0 busy1", wr_err, busy); end
      end
      lat = 0; low = 0;
      while (!res_valid && lat < 100) begin
        start = 1'($urandom_range(0, 1));
        res_ack = 1'($urandom_range(0, 1));
        w = ($urandom_range(0, 3) == 0);
        if (w) begin wr_en = 1'b1; wr_addr = 5'($urandom_range(0, 31)); wr_data = 8'($urandom); end
        tick();
        start = 1'b0; res_ack = 1'b0; wr_en = 1'b0;
        lat++;
        if (!eng_rst) low++;
        if (w) begin
          total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL rnd_busy_wr got=%b want=1", wr_err); end
        end
      end
      total++; if (lat != LAT || low != CMPC) begin bad++; $display("FAIL rnd_latency job=%0d got=%0d/%0d want=%0d/%0d", j, lat, low, LAT, CMPC); end
      total++; if (result !== conv_vec(mdl_in(), mdl_flt())) begin bad++; $display("FAIL rnd_result job=%0d got=%h want=%h", j, result, conv_vec(mdl_in(), mdl_flt())); end
      total++; if (eng_input !== mdl_in() || eng_filter !== mdl_flt()) begin bad++; $display("FAIL rnd_operands job=%0d got=%h/%h want=%h/%h", j, eng_input, eng_filter, mdl_in(), mdl_flt()); end
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        wr_en = 1'b1; wr_addr = 5'($urandom_range(0, 24)); wr_data = 8'($urandom);
        tick();
        wr_en = 1'b0;
        total++; if (res_valid !== 1'b1 || wr_err !== 1'b1) begin bad++; $display("FAIL rnd_done_wait got=valid%b err%b want=valid1 err1", res_valid, wr_err); end
      end
      ch = (j == 24) ? $urandom_range(0, 1) : $urandom_range(0, 2);
      res_ack = 1'b1;
      if (ch == 1) begin
        a = 5'($urandom_range(0, 24)); d = 8'($urandom);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        mdl[a] = d;
      end
      if (ch == 2) start = 1'b1;
      tick();
      res_ack = 1'b0; start = 1'b0; wr_en = 1'b0;
      total++; if (res_valid !== 1'b0 || busy !== (ch == 2) || wr_err !== 1'b0) begin
        bad++; $display("FAIL rnd_ack ch=%0d got=valid%b busy%b err%b want=valid0 busy%b err0", ch, res_valid, busy, wr_err, ch == 2);
      end
      total++; if (eng_input !== mdl_in() || eng_filter !== mdl_flt()) begin bad++; $display("FAIL rnd_ack_wr got=%h/%h want=%h/%h", eng_input, eng_filter, mdl_in(), mdl_flt()); end
      b2b = (ch == 2);
    end
  endtask

`ifdef CONV_TILE_CTRL_JOBCNT_EN
  task automatic test_jobcnt();
    int lat, low;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    clear_mdl();
    total++; if (job_count !== 16'd0) begin bad++; $display("FAIL jobcnt_reset got=%0d want=0", job_count); end
    for (int i = 0; i < 3; i++) begin
      start_job();
      wait_done(0, lat, low);
      res_ack = 1'b1; tick(); res_ack = 1'b0;
    end
    total++; if (job_count !== 16'd3) begin bad++; $display("FAIL jobcnt_three got=%0d want=3", job_count); end
    force dut.job_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.job_cnt_q;
    tick();
    total++; if (job_count !== 16'hFFFF) begin bad++; $display("FAIL jobcnt_preload got=%h want=ffff", job_count); end
    start_job();
    wait_done(0, lat, low);
    total++; if (job_count !== 16'h0000) begin bad++; $display("FAIL jobcnt_wrap got=%h want=0000", job_count); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed_conv();
    test_write_reject();
    test_done_hold();
    test_mid_run_reset();
    test_random();
`ifdef CONV_TILE_CTRL_JOBCNT_EN
    test_jobcnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_tile_controller.md
CONV_TILE_CONTROLLER -- requirements
Module: conv_tile_controller

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles eng_rst is held high after a job is accepted (legal range 1-15).
REQ-002 Parameter COMPUTE_CYCLES, default 12: number of cycles the engine runs with eng_rst low (legal range 1-255).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port wr_en, input, 1: host write strobe.
REQ-006 Port wr_addr, input, 5: write address. 0-15 select the input tile (row*4+col). 16-24 select the filter (16+row*3+col).
REQ-007 Port wr_data, input, 8: write data.
REQ-008 Port wr_err, output, 1: one-cycle pulse flagging a rejected write.
REQ-009 Port start, input, 1: job request, level-sampled.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port eng_rst, output, 1: reset to the 3x3 systolic engine.
REQ-012 Port eng_input, output, 128: input tile; byte k is [8k+7:8k], k = row*4+col.
REQ-013 Port eng_filter, output, 72: filter; byte k, k = row*3+col.
REQ-014 Port eng_result, input, 32: engine outputs, lanes [7:0]=r11, [15:8]=r12, [23:16]=r21, [31:24]=r22.
REQ-015 Port res_valid, output, 1: result available.
REQ-016 Port res_ack, input, 1: host consumes the result.
REQ-017 Port result, output, 32: captured eng_result, same lane packing.

Function
REQ-018 Operand storage is 25 byte registers driving eng_input and eng_filter continuously.
REQ-019 FSM states are IDLE, RST, RUN and DONE.
REQ-020 IDLE->RST when start=1; eng_rst=1 in IDLE, RST and DONE; eng_rst=0 only in RUN.
REQ-021 RST->RUN after exactly RST_CYCLES cycles in RST, counted by an internal counter.
REQ-022 RUN->DONE after exactly COMPUTE_CYCLES cycles in RUN; on that same edge result <= eng_result and res_valid <= 1.
REQ-023 Latency: res_valid rises RST_CYCLES+COMPUTE_CYCLES edges after the edge that samples start (14 with defaults).
REQ-024 DONE->IDLE on res_ack=1; res_valid clears on that edge. result holds its value until the next capture.
REQ-025 In DONE, res_ack=1 together with start=1 goes directly to RST, starting a new job with no IDLE cycle.
REQ-026 A write is accepted only in IDLE, or in DONE when res_ack=1 on the same cycle.
REQ-027 A write made while busy (outside REQ-026) or with wr_addr>=25 is discarded, and wr_err pulses for one cycle.
REQ-028 wr_en and start in the same IDLE cycle: the write lands first, and the job uses the new value.
REQ-029 start in RST or RUN is ignored and is not queued.
REQ-030 res_ack while res_valid=0 is ignored.
REQ-031 Result width is 8 bits per lane as delivered by the engine; no widening or saturation.

Reset
REQ-032 rst=1, asynchronously, at any state including mid-RUN, forces: state=IDLE, counters=0, eng_rst=1, busy=0, res_valid=0, wr_err=0, result=0, all operand bytes=0.
REQ-033 After rst deasserts, no job starts until start is sampled high.

Configuration
REQ-034 Macro CONV_TILE_CTRL_JOBCNT_EN, when defined, adds output job_count[15:0]: reset to 0, incremented on each RUN->DONE edge, wrapping 0xFFFF->0.
REQ-035 Without CONV_TILE_CTRL_JOBCNT_EN the job_count port and its logic are absent, and all other behaviour is identical.

Verification
REQ-036 Load input 10,5,1,4/6,0,12,15/3,8,0,9/11,16,25,7 and filter 1,5,3/4,0,10/0,7,15, pulse start, with a behavioural engine model -> res_valid 14 cycles later, result[7:0]=238, eng_rst low for exactly 12 cycles.
REQ-037 Write addr 5 during RUN, then write addr 27 in IDLE -> wr_err pulses each time, and eng_input byte 5 is unchanged.
REQ-038 Hold res_ack=0 for 20 cycles in DONE -> res_valid and result stable. Then res_ack+start together -> RST next cycle, no IDLE.
REQ-039 Assert rst at RUN cycle 6 -> immediate IDLE, eng_rst=1, res_valid=0, operand bytes 0. A subsequent start completes normally.
REQ-040 With CONV_TILE_CTRL_JOBCNT_EN, run 3 jobs -> job_count=3. Preload the counter to 0xFFFF via force, run 1 job -> job_count=0.
